// File: rtl/sao_stat_ctrl.sv
// SAO statistics sequencer for one CTB: clear bank, accumulate per-category diff sums/counts, drain.
// Optional macro SAO_STAT_SAT_EN: saturating sum/count with a sticky sat_flag output.
module sao_stat_ctrl #(
    parameter int PIX2          = 2,
    parameter int diff_clip_bit = 4,
    parameter int n_bo_type     = 5,
    parameter int SUM_W         = 18,
    parameter int CNT_W         = 13,
    parameter int BEAT_W        = 12
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [BEAT_W-1:0]                  ctb_beats,
    output logic                               busy,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PIX2-1:0]                    in_mask,
    input  logic [PIX2*n_bo_type-1:0]          in_cate,
    input  logic [PIX2*(diff_clip_bit+1)-1:0]  in_diff,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [n_bo_type-1:0]               out_cate,
    output logic [SUM_W-1:0]                   out_sum,
    output logic [CNT_W-1:0]                   out_cnt,
    output logic                               out_last,
    output logic                               done
`ifdef SAO_STAT_SAT_EN
    ,
    output logic                               sat_flag
`endif
);

    localparam int N_CATE = 2 ** n_bo_type;
    localparam int DW     = diff_clip_bit + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [BEAT_W-1:0]    beats_q, beats_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [n_bo_type-1:0] idx_q, idx_d;
    logic                 done_q, done_d;

    logic [SUM_W-1:0]     sum_q [N_CATE];
    logic [CNT_W-1:0]     cnt_q [N_CATE];
    logic [SUM_W-1:0]     sum_d [N_CATE];
    logic [CNT_W-1:0]     cnt_d [N_CATE];
    logic [SUM_W-1:0]     dsum  [N_CATE];
    logic [CNT_W-1:0]     dcnt  [N_CATE];
    logic [DW-1:0]        lane_diff;
    logic                 sat_hit;
`ifdef SAO_STAT_SAT_EN
    logic                 sat_q;
    logic [SUM_W:0]       wide_sum;
    logic [CNT_W:0]       wide_cnt;
`endif

    logic in_fire, out_fire, last_idx;

    // Shared lane-vs-category compare used by every per-category adder.
    function automatic logic lane_hit(input logic m, input logic [n_bo_type-1:0] lc,
                                      input logic [n_bo_type-1:0] c);
        return m && (lc == c);
    endfunction

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_idx  = (idx_q == n_bo_type'(N_CATE - 1));
    assign out_cate  = out_valid ? idx_q : '0;
    assign out_sum   = out_valid ? sum_q[idx_q] : '0;
    assign out_cnt   = out_valid ? cnt_q[idx_q] : '0;
    assign out_last  = out_valid && last_idx;
    assign done      = done_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    beats_d = ctb_beats;
                    idx_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (last_idx) begin
                    idx_d      = '0;
                    beat_cnt_d = '0;
                    state_d    = (beats_q == '0) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_fire) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q + BEAT_W'(1) == beats_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    idx_d = idx_q + 1'b1;
                    if (last_idx) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-category beat deltas and the (wrapping or clamping) next bank values.
    always_comb begin
        sat_hit   = 1'b0;
        lane_diff = '0;
`ifdef SAO_STAT_SAT_EN
        wide_sum  = '0;
        wide_cnt  = '0;
`endif
        for (int c = 0; c < N_CATE; c++) begin
            dsum[c] = '0;
            dcnt[c] = '0;
            for (int l = 0; l < PIX2; l++) begin
                if (lane_hit(in_mask[l], in_cate[l*n_bo_type +: n_bo_type], n_bo_type'(c))) begin
                    lane_diff = in_diff[l*DW +: DW];
                    dsum[c]   = dsum[c] + {{(SUM_W-DW){lane_diff[DW-1]}}, lane_diff};
                    dcnt[c]   = dcnt[c] + CNT_W'(1);
                end
            end
`ifdef SAO_STAT_SAT_EN
            wide_sum = {sum_q[c][SUM_W-1], sum_q[c]} + {dsum[c][SUM_W-1], dsum[c]};
            sum_d[c] = wide_sum[SUM_W-1:0];
            if (wide_sum[SUM_W] != wide_sum[SUM_W-1]) begin
                sum_d[c] = wide_sum[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
                sat_hit  = 1'b1;
            end
            wide_cnt = {1'b0, cnt_q[c]} + {1'b0, dcnt[c]};
            cnt_d[c] = wide_cnt[CNT_W-1:0];
            if (wide_cnt[CNT_W]) begin
                cnt_d[c] = '1;
                sat_hit  = 1'b1;
            end
`else
            sum_d[c] = sum_q[c] + dsum[c];
            cnt_d[c] = cnt_q[c] + dcnt[c];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the bank has no reset; CLEAR zeroes every entry before it is ever read.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            sum_q[idx_q] <= '0;
            cnt_q[idx_q] <= '0;
        end else if (in_fire) begin
            for (int c = 0; c < N_CATE; c++) begin
                sum_q[c] <= sum_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

`ifdef SAO_STAT_SAT_EN
    always_ff @(posedge clk) begin
        if (rst || state_q == S_CLEAR) sat_q <= 1'b0;
        else if (in_fire && sat_hit)   sat_q <= 1'b1;
    end
    assign sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_hit;
`endif

endmodule

// File: doc/sao_stat_ctrl.md
Name: sao_stat_ctrl

Overview:
Sequences SAO statistics collection for one CTB.
- Clears a per-category accumulator bank, then accepts a stream of PIX2-lane (category, clipped diff) beats and accumulates a signed diff sum and an occurrence count per category.
- Each lane-vs-target match uses the same compare-and-select as the per-category stat adders.
- Drains the bank, one category per cycle, to the SAO offset decision stage over a valid/ready handshake.

Parameters:
PIX2, 2, pixel lanes per input beat
diff_clip_bit, 4, diff is signed [diff_clip_bit:0]
n_bo_type, 5, category index width; bank depth N_CATE = 2**n_bo_type
SUM_W, 18, signed accumulator width
CNT_W, 13, count width (64x64 CTB = 4096 pixels)
BEAT_W, 12, width of beat-count request

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin CTB; sampled only in IDLE
ctb_beats  in  BEAT_W  beats to accept for this CTB, sampled with start
busy  out  1  high in every state except IDLE
in_valid  in  1  input beat valid
in_ready  out  1  high only in ACCUM
in_mask  in  PIX2  per-lane valid; masked lanes ignored
in_cate  in  PIX2*n_bo_type  lane categories, lane 0 in LSBs
in_diff  in  PIX2*(diff_clip_bit+1)  signed lane diffs, lane 0 in LSBs
out_valid  out  1  drain entry valid
out_ready  in  1  consumer accepts entry
out_cate  out  n_bo_type  category index of entry
out_sum  out  SUM_W  signed diff sum
out_cnt  out  CNT_W  pixel count
out_last  out  1  high with entry N_CATE-1
done  out  1  one-cycle pulse after final drain handshake

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset (any state, including mid-operation): FSM to IDLE; busy, in_ready, out_valid, out_last, done = 0; out_cate, out_sum, out_cnt = 0. Bank contents are don't-care because CLEAR precedes every use.
- State flow: IDLE -> CLEAR -> ACCUM -> DRAIN -> IDLE.
- IDLE: start=1 latches ctb_beats and moves to CLEAR next cycle. start is ignored in all other states.
- CLEAR: zeroes one bank entry per cycle, index 0..N_CATE-1, so it lasts N_CATE cycles.
  - After the last entry: go to ACCUM, or go directly to DRAIN if the latched ctb_beats == 0.
- ACCUM: in_ready=1. On each in_valid&&in_ready:
  - For every category c: sum[c] += sign-extended sum of in_diff over lanes with in_mask=1 and in_cate==c.
  - cnt[c] += number of such lanes.
  - Multiple lanes of one beat hitting the same category all add in the same cycle.
  - Beat counter increments. Accepting beat ctb_beats-1 deasserts in_ready the next cycle and enters DRAIN.
  - in_valid with in_mask=0 still counts as a beat.
- DRAIN: drains entries 0..N_CATE-1 in order.
  - out_valid rises the first DRAIN cycle.
  - An entry (out_cate/out_sum/out_cnt/out_last) is held stable while out_valid&&!out_ready.
  - On a handshake the index advances and the next entry is presented the following cycle, giving 1 entry/cycle under out_ready=1.
  - After the handshake with out_last=1: out_valid=0, done=1 for one cycle, state IDLE.
- Arithmetic: diff sign-extended to SUM_W. Without the optional feature, sum and cnt wrap modulo 2**SUM_W and 2**CNT_W.
- Latency: start at cycle T gives in_ready=1 at T+N_CATE+1.
  - Last beat accepted at cycle U gives out_valid=1 at U+1.
  - Final handshake at cycle V gives done=1 at V+1.

Optional Feature:
SAO_STAT_SAT_EN
- Defined: sum saturates at [-2**(SUM_W-1), 2**(SUM_W-1)-1] and cnt saturates at 2**CNT_W-1. A sticky sat_flag output (1 bit) goes high on any clamp, is cleared in CLEAR, and is valid during DRAIN.
- Undefined: wrap arithmetic as above; no sat_flag port.

Test Plan:
- Reset, then start with ctb_beats=0 -> CLEAR 32 cycles; drain 32 entries, all sum=0 and cnt=0; out_last on cate 31; done pulses once.
- ctb_beats=3, beats {(c5,+3),(c5,-1)}, {(c7,+15),(c2,-16)}, {(c5,+2),mask lane1=0} -> cate5 sum=4 cnt=3; cate7 sum=15 cnt=1; cate2 sum=-16 cnt=1; all other entries 0/0.
- Same stimulus with in_valid toggling 1/0 each cycle -> identical drained results; in_ready stays 1 throughout ACCUM.
- Drain with out_ready low for 4 cycles on entry 10 -> out_cate=10 and its sum/cnt held stable; entry 11 presented the cycle after the handshake; done only after entry 31.
- start asserted during ACCUM and during DRAIN -> ignored; rst=1 mid-ACCUM -> next cycle busy=0, in_ready=0, out_valid=0; a new start produces fresh zero-cleared results.
- SAO_STAT_SAT_EN defined, SUM_W=8, 10 beats of (c1,+15),(c1,+15) -> cate1 sum=127, cnt=20, sat_flag=1. Without the macro -> sum wraps to 300 mod 256 = 44 (signed +44).
